// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: A owns port 0; port 1 serves B first,
// then drains a small debug-write FIFO in idle, collision-free slots.
module regfile_wb_arbiter #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_wen,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_data,
   input  logic        b_wen,
   input  logic [4:0]  b_addr,
   input  logic [31:0] b_data,
   input  logic        dbg_valid,
   input  logic [4:0]  dbg_addr,
   input  logic [31:0] dbg_data,
   output logic        dbg_ready,
   output logic        wen0,
   output logic [4:0]  waddr0,
   output logic [31:0] wdata0,
   output logic        wen1,
   output logic [4:0]  waddr1,
   output logic [31:0] wdata1,
   output logic        dbg_busy,
   output logic [7:0]  coll_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [4:0]    r_mem_addr [DEPTH];
   logic [31:0]   r_mem_data [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [7:0]    r_coll_count;

   logic          w_full;
   logic          w_empty;
   logic          w_a_grant;
   logic          w_b_req;
   logic          w_b_coll;
   logic          w_b_grant;
   logic [4:0]    w_head_addr;
   logic [31:0]   w_head_data;
   logic          w_drain;
   logic          w_push;

   assign w_full      = (r_count == CW'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_head_addr = r_mem_addr[r_rptr];
   assign w_head_data = r_mem_data[r_rptr];

   // Grant logic: A always wins a same-register clash with B or the FIFO head
   assign w_a_grant = a_wen && (a_addr != 5'd0);
   assign w_b_req   = b_wen && (b_addr != 5'd0);
   assign w_b_coll  = w_b_req && w_a_grant && (b_addr == a_addr);
   assign w_b_grant = w_b_req && !w_b_coll;
   assign w_drain   = !w_empty && !w_b_req &&
                      !(w_a_grant && (w_head_addr == a_addr));

   assign dbg_ready = !w_full && !rst;
   assign w_push    = dbg_valid && dbg_ready && (dbg_addr != 5'd0);

   assign wen0       = w_a_grant && !rst;
   assign waddr0     = a_addr;
   assign wdata0     = a_data;
   assign wen1       = (w_b_grant || w_drain) && !rst;
   assign waddr1     = w_b_req ? b_addr : w_head_addr;
   assign wdata1     = w_b_req ? b_data : w_head_data;
   assign dbg_busy   = !w_empty;
   assign coll_count = r_coll_count;

   // FIFO storage needs no reset; occupancy gates every read of it
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_addr[r_wptr] <= dbg_addr;
         r_mem_data[r_wptr] <= dbg_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_coll_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_drain) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_drain);
         if (w_b_coll && (r_coll_count != 8'hFF)) begin
            r_coll_count <= r_coll_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter (DEPTH = 2).
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_wen, b_wen, dbg_valid;
   logic [4:0]  a_addr, b_addr, dbg_addr;
   logic [31:0] a_data, b_data, dbg_data;
   logic        dbg_ready, wen0, wen1, dbg_busy;
   logic [4:0]  waddr0, waddr1;
   logic [31:0] wdata0, wdata1;
   logic [7:0]  coll_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .a_wen(a_wen), .a_addr(a_addr), .a_data(a_data),
      .b_wen(b_wen), .b_addr(b_addr), .b_data(b_data),
      .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .dbg_ready(dbg_ready),
      .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
      .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
      .dbg_busy(dbg_busy), .coll_count(coll_count)
   );

   typedef struct {
      logic        rst;
      logic        a_wen;
      logic [4:0]  a_addr;
      logic [31:0] a_data;
      logic        b_wen;
      logic [4:0]  b_addr;
      logic [31:0] b_data;
      logic        dv;
      logic [4:0]  d_addr;
      logic [31:0] d_data;
      logic        e_wen0;
      logic        e_wen1;
      logic        e_chk1;
      logic [4:0]  e_waddr1;
      logic [31:0] e_wdata1;
      logic        e_ready;
      logic        e_busy;
      logic [7:0]  e_coll;
   } vec_t;

   localparam int unsigned NV = 25;
   vec_t tbl [NV];

   function automatic vec_t mk(
      input logic r, input logic aw, input logic [4:0] aa, input logic [31:0] ad,
      input logic bw, input logic [4:0] ba, input logic [31:0] bd,
      input logic dv, input logic [4:0] da, input logic [31:0] dd,
      input logic ew0, input logic ew1, input logic ec1,
      input logic [4:0] ewa1, input logic [31:0] ewd1,
      input logic er, input logic eb, input logic [7:0] ec);
      vec_t v;
      v.rst = r; v.a_wen = aw; v.a_addr = aa; v.a_data = ad;
      v.b_wen = bw; v.b_addr = ba; v.b_data = bd;
      v.dv = dv; v.d_addr = da; v.d_data = dd;
      v.e_wen0 = ew0; v.e_wen1 = ew1; v.e_chk1 = ec1;
      v.e_waddr1 = ewa1; v.e_wdata1 = ewd1;
      v.e_ready = er; v.e_busy = eb; v.e_coll = ec;
      return v;
   endfunction

   task automatic check(input string name, input int idx,
                        input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s [%0d]: got %h, required %h", name, idx, got, exp);
      end
   endtask

   task automatic idle_inputs();
      a_wen = 1'b0; a_addr = 5'd0; a_data = 32'd0;
      b_wen = 1'b0; b_addr = 5'd0; b_data = 32'd0;
      dbg_valid = 1'b0; dbg_addr = 5'd0; dbg_data = 32'd0;
   endtask

   initial begin
      //         rst a_w aa     ad          b_w ba     bd          dv da     dd          w0 w1 c1 wa1    wd1         rdy bsy coll
      tbl[0]  = mk(1, 1, 5'd5,  32'h55,     0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 0, 0, 5'd0,  32'h0,      0, 0, 8'd0);
      tbl[1]  = mk(0, 1, 5'd5,  32'h11,     0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 0, 0, 5'd0,  32'h0,      1, 0, 8'd0);
      tbl[2]  = mk(0, 1, 5'd3,  32'h100,    1, 5'd3,  32'h200,    0, 5'd0,  32'h0,      1, 0, 1, 5'd3,  32'h200,    1, 0, 8'd0);
      tbl[3]  = mk(0, 1, 5'd0,  32'h77,     0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 0, 0, 5'd0,  32'h0,      1, 0, 8'd1);
      tbl[4]  = mk(0, 0, 5'd0,  32'h0,      1, 5'd10, 32'h10,     1, 5'd7,  32'h7,      0, 1, 1, 5'd10, 32'h10,     1, 0, 8'd1);
      tbl[5]  = mk(0, 0, 5'd0,  32'h0,      1, 5'd10, 32'h11,     1, 5'd8,  32'h8,      0, 1, 1, 5'd10, 32'h11,     1, 1, 8'd1);
      tbl[6]  = mk(0, 0, 5'd0,  32'h0,      1, 5'd10, 32'h12,     1, 5'd9,  32'h9,      0, 1, 1, 5'd10, 32'h12,     0, 1, 8'd1);
      tbl[7]  = mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd9,  32'h9,      0, 1, 1, 5'd7,  32'h7,      0, 1, 8'd1);
      tbl[8]  = mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 1, 1, 5'd8,  32'h8,      1, 1, 8'd1);
      tbl[9]  = mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd9,  32'h9,      0, 0, 0, 5'd0,  32'h0,      1, 0, 8'd1);
      tbl[10] = mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 1, 1, 5'd9,  32'h9,      1, 1, 8'd1);
      tbl[11] = mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 0, 0, 5'd0,  32'h0,      1, 0, 8'd1);
      tbl[12] = mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd4,  32'hAA,     0, 0, 0, 5'd0,  32'h0,      1, 0, 8'd1);
      tbl[13] = mk(0, 1, 5'd4,  32'hBB,     0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 0, 1, 5'd4,  32'hAA,     1, 1, 8'd1);
      tbl[14] = mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 1, 1, 5'd4,  32'hAA,     1, 1, 8'd1);
      tbl[15] = mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 0, 0, 5'd0,  32'h0,      1, 0, 8'd1);
      tbl[16] = mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      1, 5'd0,  32'hDD,     0, 0, 0, 5'd0,  32'h0,      1, 0, 8'd1);
      tbl[17] = mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 0, 0, 5'd0,  32'h0,      1, 0, 8'd1);
      tbl[18] = mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 0, 0, 5'd0,  32'h0,      1, 0, 8'd1);
      tbl[19] = mk(0, 1, 5'd1,  32'h1,      1, 5'd2,  32'h2,      0, 5'd0,  32'h0,      1, 1, 1, 5'd2,  32'h2,      1, 0, 8'd1);
      tbl[20] = mk(0, 0, 5'd0,  32'h0,      1, 5'd10, 32'h3,      1, 5'd11, 32'hB1,     0, 1, 1, 5'd10, 32'h3,      1, 0, 8'd1);
      tbl[21] = mk(0, 0, 5'd0,  32'h0,      1, 5'd10, 32'h4,      1, 5'd12, 32'hB2,     0, 1, 1, 5'd10, 32'h4,      1, 1, 8'd1);
      tbl[22] = mk(1, 1, 5'd6,  32'h66,     0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 0, 0, 5'd0,  32'h0,      0, 1, 8'd1);
      tbl[23] = mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 0, 0, 5'd0,  32'h0,      1, 0, 8'd0);
      tbl[24] = mk(0, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 5'd0,  32'h0,      0, 0, 0, 5'd0,  32'h0,      1, 0, 8'd0);

      rst = 1'b1;
      idle_inputs();
      @(posedge clk);

      // Each row: drive after the falling edge, compare just before the next rising edge
      for (int i = 0; i < int'(NV); i++) begin
         @(negedge clk);
         rst = tbl[i].rst;
         a_wen = tbl[i].a_wen; a_addr = tbl[i].a_addr; a_data = tbl[i].a_data;
         b_wen = tbl[i].b_wen; b_addr = tbl[i].b_addr; b_data = tbl[i].b_data;
         dbg_valid = tbl[i].dv; dbg_addr = tbl[i].d_addr; dbg_data = tbl[i].d_data;
         #1;
         check("wen0", i, 32'(wen0), 32'(tbl[i].e_wen0));
         check("waddr0", i, 32'(waddr0), 32'(tbl[i].a_addr));
         check("wdata0", i, wdata0, tbl[i].a_data);
         check("wen1", i, 32'(wen1), 32'(tbl[i].e_wen1));
         if (tbl[i].e_chk1) begin
            check("waddr1", i, 32'(waddr1), 32'(tbl[i].e_waddr1));
            check("wdata1", i, wdata1, tbl[i].e_wdata1);
         end
         check("dbg_ready", i, 32'(dbg_ready), 32'(tbl[i].e_ready));
         check("dbg_busy", i, 32'(dbg_busy), 32'(tbl[i].e_busy));
         check("coll_count", i, 32'(coll_count), 32'(tbl[i].e_coll));
      end

      // Debug write must appear on port 1 exactly one cycle after acceptance
      begin
         int lat;
         bit seen;
         @(negedge clk);
         idle_inputs();
         dbg_valid = 1'b1; dbg_addr = 5'd13; dbg_data = 32'hC3;
         #1;
         check("seq_accept_ready", 100, 32'(dbg_ready), 32'd1);
         seen = 1'b0;
         lat = 0;
         for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            if (wen1) begin
               seen = 1'b1;
               lat = k;
            end
         end
         if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL seq_drain_timeout: wen1 not seen within 8 cycles, required within 1");
         end else begin
            check("seq_drain_latency", 101, 32'(lat), 32'd1);
            check("seq_drain_waddr1", 102, 32'(waddr1), 32'd13);
            check("seq_drain_wdata1", 103, wdata1, 32'hC3);
         end
      end

      // Saturation: 300 back-to-back A/B collisions on r3
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         idle_inputs();
         a_wen = 1'b1; a_addr = 5'd3; a_data = 32'(k);
         b_wen = 1'b1; b_addr = 5'd3; b_data = 32'hFFFF0000 | 32'(k);
         #1;
         if (k == 1 || k == 254 || k == 255 || k == 256 || k == 299) begin
            check("sat_coll_count", 200 + k, 32'(coll_count), (k > 255) ? 32'd255 : 32'(k));
            check("sat_wen1", 200 + k, 32'(wen1), 32'd0);
         end
      end
      @(negedge clk);
      idle_inputs();
      #1;
      check("sat_final", 500, 32'(coll_count), 32'd255);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
